// File: rtl/hbwordarb_if.sv
// Word-channel bundle for hbwordarb: two 34-bit sources, interrupt level, one downstream channel.
// master drives sources and downstream stall; slave is the arbiter.
interface hbwordarb_if;
  logic        interrupt;
  logic        a_stb;
  logic [33:0] a_word;
  logic        a_busy;
  logic        b_stb;
  logic [33:0] b_word;
  logic        b_busy;
  logic        stb;
  logic [33:0] word;
  logic        busy;

  modport master (
    output interrupt, a_stb, a_word, b_stb, b_word, busy,
    input  a_busy, b_busy, stb, word
  );

  modport slave (
    input  interrupt, a_stb, a_word, b_stb, b_word, busy,
    output a_busy, b_busy, stb, word
  );
endinterface

// File: rtl/hbwordarb.sv
// Hexbus output word scheduler: interrupt > round-robin A/B > idle keep-alive, one registered stage.
// Latency 1 cycle, one word/cycle; sources stall via a_busy/b_busy while the output slot is held by i_busy.
module hbwordarb #(
  parameter int          LGIDLE    = 20,
  parameter logic [33:0] INT_WORD  = {5'b11010, 29'h0},
  parameter logic [33:0] IDLE_WORD = {5'b11011, 29'h0}
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  hbwordarb_if.slave bus
);

  typedef enum logic [2:0] {G_NONE, G_INT, G_A, G_B, G_IDLE} grant_t;

  grant_t            grant;
  logic              slot_free;
  logic              out_stb;
  logic [33:0]       out_word;
  logic              int_pend;
  logic              int_armed;
  logic              rr_last;   // 1: B was granted last
  logic [LGIDLE-1:0] idle_cnt;

  assign slot_free = !out_stb || !bus.busy;

  always_comb begin
    grant = G_NONE;
    if (int_pend)
      grant = G_INT;
    else if (bus.a_stb && bus.b_stb)
      grant = rr_last ? G_A : G_B;
    else if (bus.a_stb)
      grant = G_A;
    else if (bus.b_stb)
      grant = G_B;
    else if (&idle_cnt)
      grant = G_IDLE;
  end

  assign bus.a_busy = !(slot_free && (grant == G_A));
  assign bus.b_busy = !(slot_free && (grant == G_B));
  assign bus.stb    = out_stb;
  assign bus.word   = out_word;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      out_stb   <= 1'b0;
      out_word  <= IDLE_WORD;
      int_pend  <= 1'b0;
      int_armed <= 1'b1;
      rr_last   <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      // Re-arm only once the level is low and the previous request has gone out.
      if (int_armed && bus.interrupt) begin
        int_pend  <= 1'b1;
        int_armed <= 1'b0;
      end else begin
        if (!bus.interrupt && !int_pend)
          int_armed <= 1'b1;
        if (slot_free && (grant == G_INT))
          int_pend <= 1'b0;
      end

      if (slot_free) begin
        out_stb <= (grant != G_NONE);
        case (grant)
          G_INT:   out_word <= INT_WORD;
          G_A:     out_word <= bus.a_word;
          G_B:     out_word <= bus.b_word;
          G_IDLE:  out_word <= IDLE_WORD;
          default: out_word <= out_word;
        endcase
        if (grant == G_A)
          rr_last <= 1'b0;
        else if (grant == G_B)
          rr_last <= 1'b1;
        // Quiet time counts cycles the channel goes empty; any load restarts it.
        if (grant != G_NONE)
          idle_cnt <= '0;
        else if (!(&idle_cnt))
          idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hbwordarb.sv
// Randomized bench for hbwordarb: a reference model predicts each loaded word into a queue,
// a separate monitor pops and compares every word the downstream side takes.
module tb_hbwordarb;

  localparam int          LG     = 4;
  localparam int          SAT    = (1 << LG) - 1;
  localparam logic [33:0] INT_W  = {5'b11010, 29'h0};
  localparam logic [33:0] IDLE_W = {5'b11011, 29'h0};
  localparam int W_NONE = 0, W_INT = 1, W_A = 2, W_B = 3, W_IDLE = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hbwordarb_if bus();

  hbwordarb #(.LGIDLE(LG), .INT_WORD(INT_W), .IDLE_WORD(IDLE_W)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_int = 0;
  logic chk_en = 1'b0;
  logic a_go = 1'b0, b_go = 1'b0;

  // Reference state: what the output channel should show, and the arbitration history.
  logic        m_stb, m_pend, m_armed, m_last_b;
  logic [33:0] m_word;
  int          m_quiet;
  logic [33:0] exp_q[$];

  task automatic check_bit(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [33:0] got, input logic [33:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [33:0] rand_word();
    logic [33:0] w;
    w[28:0]  = 29'($urandom);
    w[33:29] = 5'($urandom_range(0, 25));
    return w;
  endfunction

  // Who the channel should serve this cycle, from the priority rules.
  function automatic int pick(input logic a, input logic b);
    if (m_pend) return W_INT;
    if (a && b) return m_last_b ? W_A : W_B;
    if (a) return W_A;
    if (b) return W_B;
    if (m_quiet == SAT) return W_IDLE;
    return W_NONE;
  endfunction

  task automatic model_edge(input logic free, input int w);
    logic was_pend;
    if (!rst_n) begin
      m_stb = 1'b0; m_word = IDLE_W; m_pend = 1'b0; m_armed = 1'b1;
      m_last_b = 1'b0; m_quiet = 0;
      exp_q.delete();
    end else begin
      was_pend = m_pend;
      if (free && w == W_INT) m_pend = 1'b0;
      if (m_armed && bus.interrupt) begin
        m_pend = 1'b1; m_armed = 1'b0;
      end else if (!bus.interrupt && !was_pend) begin
        m_armed = 1'b1;
      end
      if (free) begin
        if (w == W_NONE) begin
          m_stb = 1'b0;
          if (m_quiet < SAT) m_quiet++;
        end else begin
          m_stb   = 1'b1;
          m_quiet = 0;
          case (w)
            W_INT:   m_word = INT_W;
            W_IDLE:  m_word = IDLE_W;
            W_A:     m_word = bus.a_word;
            default: m_word = bus.b_word;
          endcase
          if (w == W_A) m_last_b = 1'b0;
          if (w == W_B) m_last_b = 1'b1;
          exp_q.push_back(m_word);
        end
      end
    end
  endtask

  // One clock: drive at negedge, check combinational/registered outputs, advance model at posedge.
  task automatic step(input int pa, input int pb, input int pbusy, input logic intr, input logic rst);
    logic free;
    int   w;
    @(negedge clk);
    rst_n         = rst;
    bus.interrupt = intr;
    bus.busy      = ($urandom_range(0, 99) < pbusy);
    if (!bus.a_stb || a_go) begin
      bus.a_stb = ($urandom_range(0, 99) < pa);
      if (bus.a_stb) bus.a_word = rand_word();
    end
    if (!bus.b_stb || b_go) begin
      bus.b_stb = ($urandom_range(0, 99) < pb);
      if (bus.b_stb) bus.b_word = rand_word();
    end
    #1;
    free = !m_stb || !bus.busy;
    w    = pick(bus.a_stb, bus.b_stb);
    if (chk_en) begin
      check_bit("o_stb", bus.stb, m_stb);
      check_word("o_word_hold", bus.word, m_word);
      check_bit("a_busy", bus.a_busy, !(free && w == W_A));
      check_bit("b_busy", bus.b_busy, !(free && w == W_B));
    end
    a_go = bus.a_stb && !bus.a_busy && rst_n;
    b_go = bus.b_stb && !bus.b_busy && rst_n;
    @(posedge clk);
    model_edge(free, w);
    chk_en = 1'b1;
  endtask

  // Downstream monitor: every word taken must be the next predicted one.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en && bus.stb && !bus.busy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_word: got %h expected none (queue empty) at t=%0t", bus.word, $time);
        end else begin
          check_word("out_word", bus.word, exp_q.pop_front());
        end
        if (bus.word == INT_W) n_int++;
      end
    end
  end

  initial begin
    int   base, pa, pb, pbusy;
    logic intr, r;
    rst_n = 1'b0;
    bus.interrupt = 1'b0; bus.busy = 1'b0;
    bus.a_stb = 1'b0; bus.a_word = '0; bus.b_stb = 1'b0; bus.b_word = '0;

    // Reset, one A word, stall it, reset again with stall and A request held.
    step(0, 0, 0, 1'b0, 1'b0);
    step(0, 0, 0, 1'b0, 1'b0);
    step(100, 0, 0, 1'b0, 1'b1);
    step(100, 0, 100, 1'b0, 1'b1);
    step(100, 0, 100, 1'b0, 1'b1);
    step(100, 0, 100, 1'b0, 1'b0);
    step(100, 0, 100, 1'b0, 1'b0);
    a_go = 1'b1; b_go = 1'b1;

    // Quiet channel after reset, idle cadence, then an A word restarting the count.
    repeat (40) step(0, 0, 0, 1'b0, 1'b1);
    step(100, 0, 0, 1'b0, 1'b1);
    repeat (40) step(0, 0, 0, 1'b0, 1'b1);

    // Contention, then a 5-cycle stall.
    repeat (40) step(100, 100, 0, 1'b0, 1'b1);
    step(100, 0, 0, 1'b0, 1'b1);
    repeat (5) step(100, 0, 100, 1'b0, 1'b1);
    repeat (3) step(100, 0, 0, 1'b0, 1'b1);

    // Long interrupt level under continuous A traffic yields exactly one INT word.
    repeat (5) step(100, 0, 0, 1'b0, 1'b1);
    base = n_int;
    repeat (50) step(100, 0, 0, 1'b1, 1'b1);
    repeat (10) step(100, 0, 0, 1'b0, 1'b1);
    check_int("int_once", n_int - base, 1);

    // Two short interrupt pulses while the output is stalled.
    repeat (3) step(100, 0, 100, 1'b0, 1'b1);
    step(100, 0, 100, 1'b1, 1'b1);
    step(100, 0, 100, 1'b0, 1'b1);
    step(100, 0, 100, 1'b1, 1'b1);
    repeat (4) step(100, 0, 100, 1'b0, 1'b1);
    repeat (10) step(100, 0, 0, 1'b0, 1'b1);

    // Random mix, with occasional interrupt toggles and resets.
    intr = 1'b0;
    for (int blk = 0; blk < 30; blk++) begin
      pa    = $urandom_range(0, 100);
      pb    = $urandom_range(0, 100);
      pbusy = $urandom_range(0, 80);
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(0, 19) == 0) intr = !intr;
        r = ($urandom_range(0, 299) != 0);
        step(pa, pb, pbusy, intr, r);
        if (!r) begin a_go = 1'b1; b_go = 1'b1; end
      end
    end

    // Drain and confirm nothing predicted was left undelivered.
    repeat (60) step(0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    #3;
    check_int("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
